// File: rtl/gyro_drx_deframer.sv
// Gyro DRX link receive deframer: DSYNC-aligned MSB-first word assembly,
// first-word-fall-through FIFO, valid/ready output stream and status counters.
module gyro_drx_deframer #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          bit_tick,
    input  logic                          drx,
    input  logic                          dsync,
    output logic [WORD_W-1:0]             m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              words_rx,
    output logic [CNT_W-1:0]              overflow_cnt,
    output logic [CNT_W-1:0]              sync_err_cnt,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned BC_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SHIFT
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shreg, shreg_nxt;
    logic [BC_W-1:0]     bitcnt, bitcnt_nxt;
    logic [WORD_W-1:0]   word_c;
    logic                word_done;
    logic                sync_err;

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]    rd_ptr, rd_ptr_nxt, rd_ptr_inc;
    logic [LVL_W-1:0]    level_nxt;
    logic [WORD_W-1:0]   head_nxt;
    logic                full, pop, push, drop;

    assign word_c = {shreg[WORD_W-2:0], drx};

    // Framing FSM: next state, shift register and bit count
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        word_done  = 1'b0;
        sync_err   = 1'b0;
        if (flush) begin
            state_nxt  = enable ? HUNT : IDLE;
            shreg_nxt  = '0;
            bitcnt_nxt = '0;
        end else if (!enable) begin
            state_nxt  = IDLE;
            shreg_nxt  = '0;
            bitcnt_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = HUNT;
                HUNT: begin
                    if (bit_tick && dsync) begin
                        state_nxt  = SHIFT;
                        shreg_nxt  = WORD_W'(drx);
                        bitcnt_nxt = BC_W'(1);
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        // a sync mid-word realigns onto this bit
                        if (dsync && bitcnt != '0) begin
                            sync_err   = 1'b1;
                            shreg_nxt  = WORD_W'(drx);
                            bitcnt_nxt = BC_W'(1);
                        end else if (bitcnt == BC_W'(WORD_W - 1)) begin
                            word_done  = 1'b1;
                            shreg_nxt  = word_c;
                            bitcnt_nxt = '0;
                        end else begin
                            shreg_nxt  = word_c;
                            bitcnt_nxt = bitcnt + BC_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO control: flush beats push and pop; a pop frees room for a push when full
    always_comb begin
        full       = (fifo_level == LVL_W'(FIFO_DEPTH));
        pop        = m_tvalid && m_tready && !flush;
        push       = word_done && (!full || pop);
        drop       = word_done && full && !pop;
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = fifo_level;
        head_nxt   = m_tdata;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_nxt = rd_ptr_inc;
            if (push && !pop)      level_nxt = fifo_level + LVL_W'(1);
            else if (pop && !push) level_nxt = fifo_level - LVL_W'(1);
            // registered head: next stored entry, or the incoming word when it becomes head
            if (pop) begin
                head_nxt = (fifo_level > LVL_W'(1)) ? mem[rd_ptr_inc] : word_c;
            end else if (fifo_level == '0 && push) begin
                head_nxt = word_c;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            busy   <= (state_nxt == SHIFT);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= word_c;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            words_rx     <= '0;
            overflow_cnt <= '0;
            sync_err_cnt <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fifo_level <= level_nxt;
            m_tvalid   <= (level_nxt != '0);
            m_tdata    <= head_nxt;
            if (push) words_rx <= words_rx + CNT_W'(1);
            if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
            if (sync_err && sync_err_cnt != '1) sync_err_cnt <= sync_err_cnt + CNT_W'(1);
        end
    end

endmodule
